// File: rtl/reverb_pkg.sv
// Shared constants, FSM state and mix encodings for the reverb feedback/mix stage.
package reverb_pkg;

  localparam int SAMPLE_W = 32;
  localparam int GAIN_W   = 16;
  localparam int BURST_W  = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXCITE = 2'd1,
    RING   = 2'd2
  } state_t;

  localparam logic [1:0] MIX_DRY = 2'd0;
  localparam logic [1:0] MIX_WET = 2'd1;
  localparam logic [1:0] MIX_AVG = 2'd2;
  localparam logic [1:0] MIX_SUM = 2'd3;

  localparam logic [SAMPLE_W-1:0] SAT_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] SAT_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

endpackage

// File: rtl/reverb_feedback_mix_if.sv
// Sample-rate bus between the reverb control/delay line and the feedback/mix stage.
interface reverb_feedback_mix_if
  import reverb_pkg::*;
();

  logic                sample_en;
  logic                trig;
  logic [BURST_W-1:0]  burst_len;
  logic [GAIN_W-1:0]   decay_gain;
  logic [1:0]          mix_sel;
  logic [SAMPLE_W-1:0] dry_in;
  logic [SAMPLE_W-1:0] wet_in;
  logic [SAMPLE_W-1:0] fb_out;
  logic [SAMPLE_W-1:0] mix_out;
  logic                out_valid;
  logic                busy;

  modport master (
    output sample_en, trig, burst_len, decay_gain, mix_sel, dry_in, wet_in,
    input  fb_out, mix_out, out_valid, busy
  );

  modport slave (
    input  sample_en, trig, burst_len, decay_gain, mix_sel, dry_in, wet_in,
    output fb_out, mix_out, out_valid, busy
  );

endinterface

// File: rtl/reverb_sat.sv
// Signed narrowing from IN_W to SAMPLE_W bits.
// Build option REVERB_FB_SAT_EN: clamp to SAT_MAX/SAT_MIN; otherwise keep the low bits (wrap).
module reverb_sat
  import reverb_pkg::*;
#(
  parameter int IN_W = SAMPLE_W + 1
) (
  input  logic [IN_W-1:0]     din,
  output logic [SAMPLE_W-1:0] dout
);

`ifdef REVERB_FB_SAT_EN
  logic [IN_W-SAMPLE_W:0] head;
  logic                   fits;

  // The value fits when every bit from the target sign bit upward agrees.
  assign head = din[IN_W-1:SAMPLE_W-1];
  assign fits = (&head) | ~(|head);
  assign dout = fits ? din[SAMPLE_W-1:0] : (din[IN_W-1] ? SAT_MIN : SAT_MAX);
`else
  logic unused_head;

  assign dout        = din[SAMPLE_W-1:0];
  assign unused_head = ^din[IN_W-1:SAMPLE_W];
`endif

endmodule

// File: rtl/reverb_feedback_mix.sv
// Reverb feedback (decay + gated dry excitation) and dry/wet mix, two-stage pipeline.
// Build option REVERB_FB_SAT_EN (in reverb_sat): saturating instead of wrapping fb_out / sum-mix.
module reverb_feedback_mix
  import reverb_pkg::*;
#(
  parameter int SAMPLE_W = reverb_pkg::SAMPLE_W,
  parameter int GAIN_W   = reverb_pkg::GAIN_W,
  parameter int RING_LEN = 4096
) (
  input logic                  clk,
  input logic                  reset,
  reverb_feedback_mix_if.slave bus
);

  localparam int PROD_W   = SAMPLE_W + GAIN_W + 1;
  localparam int SCALED_W = PROD_W - GAIN_W;
  localparam int FB_W     = SCALED_W + 1;
  localparam int RING_W   = $clog2(RING_LEN + 1);

  state_t              state, state_nxt;
  logic                trig_q, trig_rise, excite;
  logic [BURST_W-1:0]  burst_cnt, burst_load;
  logic [RING_W-1:0]   ring_cnt;
  logic                burst_last, ring_last;

  assign trig_rise  = bus.trig & ~trig_q;
  assign burst_load = (bus.burst_len == '0) ? BURST_W'(1) : bus.burst_len;
  assign burst_last = bus.sample_en && (burst_cnt == BURST_W'(1));
  assign ring_last  = bus.sample_en && (ring_cnt == RING_W'(1));

  // trig_q resets high so a trig held through reset is not seen as an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      trig_q    <= 1'b1;
      burst_cnt <= '0;
      ring_cnt  <= '0;
    end else begin
      state  <= state_nxt;
      trig_q <= bus.trig;
      if (trig_rise) begin
        burst_cnt <= burst_load;
      end else if (state == EXCITE && bus.sample_en) begin
        burst_cnt <= burst_cnt - BURST_W'(1);
        if (burst_last) ring_cnt <= RING_W'(RING_LEN);
      end else if (state == RING && bus.sample_en) begin
        ring_cnt <= ring_cnt - RING_W'(1);
      end
    end
  end

  // A trig edge always takes priority over a terminal count.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (trig_rise) state_nxt = EXCITE;
      EXCITE:  if (trig_rise) state_nxt = EXCITE;
               else if (burst_last) state_nxt = RING;
      RING:    if (trig_rise) state_nxt = EXCITE;
               else if (ring_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
    excite   = (state == EXCITE);
  end

  logic signed [PROD_W-1:0] prod, prod_q;
  logic [SAMPLE_W-1:0]      dry_g_q, dry_q, wet_q;
  logic [1:0]               sel_q;
  logic                     v1;

  assign prod = $signed(bus.wet_in) * $signed({1'b0, bus.decay_gain});

  always_ff @(posedge clk) begin
    if (reset) begin
      v1      <= 1'b0;
      prod_q  <= '0;
      dry_g_q <= '0;
      dry_q   <= '0;
      wet_q   <= '0;
      sel_q   <= MIX_DRY;
    end else begin
      v1 <= bus.sample_en;
      if (bus.sample_en) begin
        prod_q  <= prod;
        dry_g_q <= excite ? bus.dry_in : '0;
        dry_q   <= bus.dry_in;
        wet_q   <= bus.wet_in;
        sel_q   <= bus.mix_sel;
      end
    end
  end

  logic [SCALED_W-1:0] scaled;
  logic [FB_W-1:0]     fb_sum;
  logic [SAMPLE_W:0]   mix_add;
  logic [SAMPLE_W-1:0] fb_val, sum_val, mix_val;
  logic                unused_bits;

  // The Q0.16 gain shift drops the low product bits.
  assign scaled      = prod_q[PROD_W-1:GAIN_W];
  assign fb_sum      = {scaled[SCALED_W-1], scaled} +
                       {{(FB_W-SAMPLE_W){dry_g_q[SAMPLE_W-1]}}, dry_g_q};
  assign mix_add     = {dry_q[SAMPLE_W-1], dry_q} + {wet_q[SAMPLE_W-1], wet_q};
  assign unused_bits = ^prod_q[GAIN_W-1:0];

  reverb_sat #(.IN_W(FB_W))       u_fb_sat  (.din(fb_sum),  .dout(fb_val));
  reverb_sat #(.IN_W(SAMPLE_W+1)) u_mix_sat (.din(mix_add), .dout(sum_val));

  always_comb begin
    mix_val = dry_q;
    case (sel_q)
      MIX_DRY: mix_val = dry_q;
      MIX_WET: mix_val = wet_q;
      MIX_AVG: mix_val = mix_add[SAMPLE_W:1];
      default: mix_val = sum_val;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.fb_out    <= '0;
      bus.mix_out   <= '0;
    end else begin
      bus.out_valid <= v1;
      if (v1) begin
        bus.fb_out  <= fb_val;
        bus.mix_out <= mix_val;
      end
    end
  end

endmodule
